// File: rtl/if_stage.sv
// Instruction fetch stage: owns the fetch PC and the IF/ID pipeline register.
// Each edge does exactly one of four things, highest priority first:
// reset, stall (hold), redirect (branch/jump with a squash bubble),
// or a normal sequential fetch.
//
// No valid/ready handshake exists here. Decode asserts stall to freeze the
// stage. doBranch_id is honoured only on an unstalled edge, and decode
// already gates it with valid_id.
module if_stage #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] NOP          = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        doBranch_id,
  input  logic        jump_id,
  input  logic [31:0] imm_for_branch,
  input  logic [25:0] j_address_id,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] pc,
  output logic [31:0] inst,
  output logic        valid_id,
  output logic [31:0] fetch_count
);

  logic [31:0] pc_f_d, pc_f_q;
  logic [31:0] pc_d, pc_q;
  logic [31:0] inst_d, inst_q;
  logic        valid_id_d, valid_id_q;
  logic [31:0] fetch_count_d, fetch_count_q;

  logic [31:0] pc_plus4;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic [31:0] redirect_target;

  // Target arithmetic: both targets are relative to the IF/ID PC (the branch's own PC+4).
  always_comb begin
    pc_plus4        = pc_f_q + 32'd4;
    branch_target   = pc_q + {imm_for_branch[29:0], 2'b00};
    jump_target     = {pc_q[31:28], j_address_id, 2'b00};
    redirect_target = jump_id ? jump_target : branch_target;
  end

  // Next-state selection: reset > stall > redirect > sequential fetch.
  always_comb begin
    pc_f_d        = pc_f_q;
    pc_d          = pc_q;
    inst_d        = inst_q;
    valid_id_d    = valid_id_q;
    fetch_count_d = fetch_count_q;
    if (reset) begin
      pc_f_d        = RESET_VECTOR;
      pc_d          = 32'd0;
      inst_d        = NOP;
      valid_id_d    = 1'b0;
      fetch_count_d = 32'd0;
    end else if (stall) begin
      // Hold everything. A pending redirect is re-presented by decode later.
    end else if (doBranch_id) begin
      // Squash the wrong-path word fetched this cycle with a NOP bubble.
      pc_f_d     = redirect_target;
      pc_d       = pc_plus4;
      inst_d     = NOP;
      valid_id_d = 1'b0;
    end else begin
      pc_f_d        = pc_plus4;
      pc_d          = pc_plus4;
      inst_d        = imem_data;
      valid_id_d    = 1'b1;
      fetch_count_d = fetch_count_q + 32'd1;
    end
  end

  // State registers; reset is folded into the next-state logic above.
  always_ff @(posedge clk) begin
    pc_f_q        <= pc_f_d;
    pc_q          <= pc_d;
    inst_q        <= inst_d;
    valid_id_q    <= valid_id_d;
    fetch_count_q <= fetch_count_d;
  end

  // Outputs come straight from the registers; the memory address is the fetch PC.
  always_comb begin
    imem_addr   = pc_f_q;
    pc          = pc_q;
    inst        = inst_q;
    valid_id    = valid_id_q;
    fetch_count = fetch_count_q;
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: a spec-level model checked every cycle, plus
// literal expectations at the key points of each scenario.
module tb_if_stage;

  localparam logic [31:0] RV   = 32'h0000_0000;
  localparam logic [31:0] NOPW = 32'h0000_0000;

  // ---------------- clock / reset ----------------
  logic        clk;
  logic        reset;
  logic        stall;
  logic        doBranch_id;
  logic        jump_id;
  logic [31:0] imm_for_branch;
  logic [25:0] j_address_id;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        valid_id;
  logic [31:0] fetch_count;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Instruction memory: every low-halfword address gives a distinct word.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  assign imem_data = mem_word(imem_addr);

  if_stage #(.RESET_VECTOR(RV), .NOP(NOPW)) dut (
    .clk(clk), .reset(reset), .stall(stall), .doBranch_id(doBranch_id),
    .jump_id(jump_id), .imm_for_branch(imm_for_branch),
    .j_address_id(j_address_id), .imem_addr(imem_addr), .imem_data(imem_data),
    .pc(pc), .inst(inst), .valid_id(valid_id), .fetch_count(fetch_count)
  );

  // ---------------- scoreboard counters ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_pc_f, m_pc, m_inst, m_cnt;
  logic        m_valid;
  bit          m_known = 0;

  always @(posedge clk) begin
    logic [31:0] tgt;
    if (reset) begin
      m_pc_f = RV; m_pc = 0; m_inst = NOPW; m_valid = 0; m_cnt = 0;
      m_known = 1;
    end else if (m_known && !stall) begin
      if (doBranch_id) begin
        tgt = jump_id ? {m_pc[31:28], j_address_id, 2'b00}
                      : m_pc + imm_for_branch * 32'd4;
        m_pc    = m_pc_f + 32'd4;
        m_inst  = NOPW;
        m_valid = 0;
        m_pc_f  = tgt;
      end else begin
        m_pc    = m_pc_f + 32'd4;
        m_inst  = mem_word(m_pc_f);
        m_valid = 1;
        m_cnt   = m_cnt + 1;
        m_pc_f  = m_pc_f + 32'd4;
      end
    end
    #1;
    if (m_known) begin
      chk("cyc_imem_addr", imem_addr, m_pc_f);
      chk("cyc_pc", pc, m_pc);
      chk("cyc_inst", inst, m_inst);
      chk("cyc_valid", {31'd0, valid_id}, {31'd0, m_valid});
      chk("cyc_count", fetch_count, m_cnt);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input logic s, input logic b, input logic j,
                       input logic [31:0] imm, input logic [25:0] ja);
    stall = s; doBranch_id = b; jump_id = j; imm_for_branch = imm; j_address_id = ja;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 32'd0, 26'd0);
    step(2);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_valid", {31'd0, valid_id}, 32'd0);
    chk("rst_count", fetch_count, 32'd0);

    // Sequential fetch: first edge presents word at RESET_VECTOR
    reset = 1'b0;
    step(1);
    chk("seq_first_inst", inst, 32'h0000_FFFF);
    chk("seq_first_pc", pc, 32'd4);
    step(3);
    chk("seq_inst3", inst, 32'h000C_FFF3);
    chk("seq_pc4", pc, 32'd16);
    chk("seq_count4", fetch_count, 32'd4);
    chk("seq_addr", imem_addr, 32'd16);

    // Taken BEQ with pc=16, offset -2 words -> target 8, one bubble
    drive(0, 1, 0, 32'hFFFF_FFFE, 26'd0);
    step(1);
    chk("beq_addr", imem_addr, 32'd8);
    chk("beq_inst_nop", inst, 32'h0);
    chk("beq_valid", {31'd0, valid_id}, 32'd0);
    chk("beq_count_hold", fetch_count, 32'd4);

    // Stall three edges at pc_f=8
    drive(1, 0, 0, 32'd0, 26'd0);
    step(3);
    chk("stall_addr", imem_addr, 32'd8);
    chk("stall_inst", inst, 32'h0);
    chk("stall_pc", pc, 32'd20);
    chk("stall_count", fetch_count, 32'd4);
    drive(0, 0, 0, 32'd0, 26'd0);
    step(1);
    chk("resume_inst", inst, 32'h0008_FFF7);
    chk("resume_pc", pc, 32'd12);
    chk("resume_count", fetch_count, 32'd5);

    // Stall and branch together: held; then branch alone redirects to 12+12=24
    drive(1, 1, 0, 32'd3, 26'd0);
    step(1);
    chk("sb_addr_held", imem_addr, 32'd12);
    chk("sb_inst_held", inst, 32'h0008_FFF7);
    drive(0, 1, 0, 32'd3, 26'd0);
    step(1);
    chk("sb_redirect", imem_addr, 32'd24);
    chk("sb_bubble", {31'd0, valid_id}, 32'd0);
    drive(0, 0, 0, 32'd0, 26'd0);
    step(1);
    chk("sb_target_inst", inst, 32'h0018_FFE7);
    chk("sb_count", fetch_count, 32'd6);

    // Branch far up to 0x1000_000C (pc=28), then fetch so pc=0x1000_0010
    drive(0, 1, 0, 32'h03FF_FFFC, 26'd0);
    step(1);
    chk("far_addr", imem_addr, 32'h1000_000C);
    drive(0, 0, 0, 32'd0, 26'd0);
    step(1);
    chk("far_pc", pc, 32'h1000_0010);

    // Jump with j_address_id=0x40 -> 0x1000_0100
    drive(0, 1, 1, 32'h1234_5678, 26'h40);
    step(1);
    chk("jmp_addr", imem_addr, 32'h1000_0100);
    chk("jmp_valid", {31'd0, valid_id}, 32'd0);
    drive(0, 0, 1, 32'd0, 26'h3FF_FFFF);   // jump_id don't-care here
    step(1);
    chk("jmp_inst", inst, 32'h0100_FEFF);
    chk("jmp_pc", pc, 32'h1000_0104);

    // Branch to 0xFFFF_FFFC, then a normal edge wraps to 0
    drive(0, 1, 0, 32'h3BFF_FFBE, 26'd0);
    step(1);
    chk("wrap_pre_addr", imem_addr, 32'hFFFF_FFFC);
    drive(0, 0, 0, 32'd0, 26'd0);
    step(1);
    chk("wrap_addr", imem_addr, 32'h0);
    chk("wrap_pc", pc, 32'h0);
    chk("wrap_inst", inst, 32'hFFFC_0003);

    // Reset during a stall with a branch pending
    drive(1, 0, 0, 32'd0, 26'd0);
    step(1);
    reset = 1'b1;
    drive(1, 1, 1, 32'd5, 26'h55);
    step(1);
    chk("rst2_addr", imem_addr, RV);
    chk("rst2_pc", pc, 32'h0);
    chk("rst2_inst", inst, NOPW);
    chk("rst2_valid", {31'd0, valid_id}, 32'd0);
    chk("rst2_count", fetch_count, 32'd0);
    reset = 1'b0;
    drive(0, 0, 0, 32'd0, 26'd0);
    step(1);
    chk("post_rst_inst", inst, 32'h0000_FFFF);
    chk("post_rst_pc", pc, 32'd4);
    chk("post_rst_count", fetch_count, 32'd1);
    step(2);

    // ---------------- final report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
